// File: rtl/node_backprop.sv
// node_backprop: backward pass of one neuron (sigmoid derivative, delta, weight/bias update, error propagation)
// sharing a single signed Q7.24 multiplier across a small FSM, one multiply per cycle.
module node_backprop #(
  parameter int sx = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [32*sx-1:0] nx,
  input  logic [32*sx-1:0] nw,
  input  logic [31:0]     b,
  input  logic [31:0]     y,
  input  logic [31:0]     err,
  input  logic [31:0]     lr,
  output logic            busy,
  output logic            done,
  output logic [32*sx-1:0] nw_new,
  output logic [31:0]     b_new,
  output logic [32*sx-1:0] ne
);
  localparam int n = 32;
  localparam int f = 24;
  localparam logic [n-1:0] one = 32'h0100_0000;
  localparam int jw = (sx > 1) ? $clog2(sx) : 1;
  typedef enum logic [2:0] {IDLE, DSIG, DELTA, LRD, BACK, UPD, DONE} state_t;
  state_t state_q, state_d;
  logic [jw-1:0] j_q, j_d;
  logic [n*sx-1:0] x_q, x_d, w_q, w_d, nw_new_q, nw_new_d, ne_q, ne_d;
  logic [n-1:0] b_q, b_d, y_q, y_d, err_q, err_d, lr_q, lr_d;
  logic [n-1:0] t_q, t_d, delta_q, delta_d, g_q, g_d, b_new_q, b_new_d;
  logic [n-1:0] ma, mb, xj, wj, prod;
  logic signed [2*n-1:0] full;
  assign xj = x_q[j_q*n +: n];
  assign wj = w_q[j_q*n +: n];
  // Operand routing for the shared multiplier; product keeps bits [i:-f] with floor rounding
  always_comb begin
    ma = state_q == DSIG ? y_q : state_q == DELTA ? err_q : state_q == LRD ? lr_q :
         state_q == BACK ? delta_q : g_q;
    mb = state_q == DSIG ? one - y_q : state_q == DELTA ? t_q : state_q == LRD ? delta_q :
         state_q == BACK ? wj : xj;
    full = $signed(ma) * $signed(mb);
    prod = n'(full >>> f);
  end
  always_comb begin
    state_d = state_q;
    j_d = j_q;
    x_d = x_q;
    w_d = w_q;
    b_d = b_q;
    y_d = y_q;
    err_d = err_q;
    lr_d = lr_q;
    t_d = t_q;
    delta_d = delta_q;
    g_d = g_q;
    b_new_d = b_new_q;
    nw_new_d = nw_new_q;
    ne_d = ne_q;
    case (state_q)
      IDLE: if (start) begin
        x_d = nx;
        w_d = nw;
        b_d = b;
        y_d = y;
        err_d = err;
        lr_d = lr;
        j_d = '0;
        state_d = DSIG;
      end
      DSIG: begin
        t_d = prod;
        state_d = DELTA;
      end
      DELTA: begin
        delta_d = prod;
        state_d = LRD;
      end
      LRD: begin
        g_d = prod;
        b_new_d = b_q - prod;
        j_d = '0;
        state_d = BACK;
      end
      BACK: begin
        ne_d[j_q*n +: n] = prod;
        state_d = UPD;
      end
      UPD: begin
        nw_new_d[j_q*n +: n] = wj - prod;
        if (j_q == jw'(sx - 1)) state_d = DONE;
        else begin
          j_d = j_q + jw'(1);
          state_d = BACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      j_q <= '0;
      x_q <= '0;
      w_q <= '0;
      b_q <= '0;
      y_q <= '0;
      err_q <= '0;
      lr_q <= '0;
      t_q <= '0;
      delta_q <= '0;
      g_q <= '0;
      b_new_q <= '0;
      nw_new_q <= '0;
      ne_q <= '0;
    end else begin
      state_q <= state_d;
      j_q <= j_d;
      x_q <= x_d;
      w_q <= w_d;
      b_q <= b_d;
      y_q <= y_d;
      err_q <= err_d;
      lr_q <= lr_d;
      t_q <= t_d;
      delta_q <= delta_d;
      g_q <= g_d;
      b_new_q <= b_new_d;
      nw_new_q <= nw_new_d;
      ne_q <= ne_d;
    end
  end
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  assign nw_new = nw_new_q;
  assign b_new = b_new_q;
  assign ne = ne_q;
endmodule

// File: tb/tb_node_backprop.sv
// tb_node_backprop: table-driven vectors with a scoreboard queue, plus hand-written
// sequences for start-while-busy, asynchronous reset mid-operation and input changes after start.
module tb_node_backprop;
  localparam logic [31:0] one = 32'h0100_0000;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [63:0] nx = '0, nw = '0, nw_new, ne;
  logic [31:0] b = '0, y = '0, err = '0, lr = '0, b_new;
  logic busy, done;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] x0, x1, w0, w1, b, y, err, lr;
    logic [31:0] nw0, nw1, bn, ne0, ne1;
    bit pert;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];

  node_backprop #(.sx(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nx(nx), .nw(nw), .b(b), .y(y),
    .err(err), .lr(lr), .busy(busy), .done(done), .nw_new(nw_new), .b_new(b_new), .ne(ne)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] tr(logic [31:0] a, logic [31:0] c);
    logic signed [63:0] p;
    p = $signed(a) * $signed(c);
    return p[55:24];
  endfunction

  function automatic vec_t model(vec_t v);
    logic [31:0] t, d, g;
    t = tr(v.y, one - v.y);
    d = tr(v.err, t);
    g = tr(v.lr, d);
    v.bn = v.b - g;
    v.ne0 = tr(d, v.w0);
    v.ne1 = tr(d, v.w1);
    v.nw0 = v.w0 - tr(g, v.x0);
    v.nw1 = v.w1 - tr(g, v.x1);
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    nx = {v.x1, v.x0};
    nw = {v.w1, v.w0};
    b = v.b;
    y = v.y;
    err = v.err;
    lr = v.lr;
  endtask

  // Drives start into edge 0; returns #1 after that edge
  task automatic launch(vec_t v, bit push);
    @(negedge clk);
    apply(v);
    start = 1'b1;
    if (push) sb.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done && cyc < 40);
    chk("done_seen", done, 1);
  endtask

  task automatic check_res(string tag);
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty got done want queued result", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_b_new"}, b_new, e.bn);
    chk({tag, "_nw_new"}, nw_new, {e.nw1, e.nw0});
    chk({tag, "_ne"}, ne, {e.ne1, e.ne0});
    chk({tag, "_busy_at_done"}, busy, 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int cyc, nd;
    vec_t v, v2;
    tbl.push_back('{32'h0100_0000, 32'hFE00_0000, 32'h0080_0000, 32'h0040_0000, 32'h0,
                    32'h0080_0000, 32'h0100_0000, 32'h0080_0000,
                    32'h0060_0000, 32'h0080_0000, 32'hFFE0_0000, 32'h0020_0000, 32'h0010_0000, 1'b0});
    tbl.push_back('{one, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0080_0000, 32'hFF00_0000, 32'h0000_0001,
                    32'h0000_0001, 32'h0, 32'h0000_0001, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{32'h0123_4567, 32'hF765_4321, 32'h1234_5678, 32'hFEDC_BA98, 32'h0ABC_DEF0,
                    32'h0080_0000, 32'h0, 32'h0080_0000,
                    32'h1234_5678, 32'hFEDC_BA98, 32'h0ABC_DEF0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{32'h0200_0000, 32'h0300_0000, 32'h0345_6789, 32'hF111_2222, 32'hF0F0_F0F0,
                    one, 32'h00C0_0000, 32'h0100_0000,
                    32'h0345_6789, 32'hF111_2222, 32'hF0F0_F0F0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{32'h0200_0000, 32'h0300_0000, 32'h0345_6789, 32'hF111_2222, 32'h1111_0000,
                    32'h0, 32'hFF40_0000, 32'h0100_0000,
                    32'h0345_6789, 32'hF111_2222, 32'h1111_0000, 32'h0, 32'h0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      v = '{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom_range(32'h0100_0000),
            $urandom, $urandom_range(32'h0080_0000), 0, 0, 0, 0, 0, 1'b0};
      tbl.push_back(model(v));
    end
    v = tbl[0];
    v.pert = 1'b1;
    tbl.push_back(v);

    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_outs", {b_new, nw_new, ne}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      launch(tbl[k], 1'b1);
      if (tbl[k].pert) begin
        nx = ~nx;
        nw = nw + 64'h0100_0000_0100_0000;
        err = 32'h0300_0000;
        lr = 32'h0040_0000;
      end
      wait_done(0, cyc);
      chk($sformatf("latency_v%0d", k), cyc, 7);
      check_res($sformatf("v%0d", k));
    end

    // start reasserted at edge 3 with other operands must be ignored
    launch(tbl[0], 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    v2 = tbl[5];
    apply(v2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3, cyc);
    chk("busy_start_latency", cyc, 7);
    check_res("busy_start");
    nd = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("busy_start_no_second_done", nd, 0);

    // asynchronous reset between edges 4 and 5
    launch(tbl[5], 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_b_new", b_new, 0);
    chk("async_rst_nw_ne", {nw_new, ne}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(tbl[0], 1'b1);
    wait_done(0, cyc);
    chk("post_rst_latency", cyc, 7);
    check_res("post_rst");

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/node_backprop.md
Name: node_backprop

Overview:
- Backward-pass counterpart of the forward neural-network node; one instance per forward node.
- Inputs:
  - the node's latched forward data: inputs x, weights w, bias b, activation y;
  - the error term dL/dy.
- Outputs:
  - updated weights and bias;
  - the error propagated back to each input, computed with the old weights.
- Time-multiplexes a single signed n-by-n multiplier under a small FSM.
- Fixed-point format is the team-wide Qi.f: n=32, i=7, f=24, one = 0x01000000.

Parameters:
- sx, 2, number of inputs/weights handled by the node.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- nx  input  n*sx  packed inputs x; element j = nx[j*n +: n], element 0 in LSBs.
- nw  input  n*sx  packed current weights, same packing as nx.
- b  input  n  current bias.
- y  input  n  forward activation (sigmoid output) of this node.
- err  input  n  dL/dy for this node.
- lr  input  n  learning rate.
- busy  output  1  high in the compute states (DSIG through UPD).
- done  output  1  one-cycle pulse; results valid.
- nw_new  output  n*sx  updated weights, same packing as nw.
- b_new  output  n  updated bias.
- ne  output  n*sx  propagated error, ne[j] = delta*w[j] using the old w.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, j=0;
  - busy=0, done=0;
  - nw_new, b_new, ne and all internal registers = 0.
- Reset mid-operation aborts the operation; no partial results are held as valid.
- Arithmetic rules:
  - every product is a full 2n-bit signed product, then truncated to bits [i:-f];
  - truncation means arithmetic drop of the f LSBs, i.e. floor toward -inf, and discard of the upper i+1 bits;
  - adds and subtracts are n-bit and wrap; there is no saturation anywhere.
- On the start edge in IDLE:
  - latch nx, nw, b, y, err, lr into internal registers;
  - further input changes are ignored until the next start.
- States, one multiply per cycle:
  - IDLE: start=1 -> latch inputs, go to DSIG.
  - DSIG: t = trunc(y*(one-y)); go to DELTA.
  - DELTA: delta = trunc(err*t); go to LRD.
  - LRD: g = trunc(lr*delta); b_new = b - g; j=0; go to BACK.
  - BACK: ne[j] = trunc(delta*w[j]); go to UPD.
  - UPD: nw_new[j] = w[j] - trunc(g*x[j]); if j==sx-1 go to DONE, else j=j+1 and go to BACK.
  - DONE: done=1, busy=0; go to IDLE.
- Latency:
  - done is high in the cycle following the (3+2*sx)-th rising edge after the edge that sampled start;
  - for sx=2 that is 7 edges.
- start handling:
  - start while busy or in DONE is ignored and is not queued;
  - back-to-back operation therefore needs start reasserted in IDLE, giving a minimum period of 5+2*sx cycles.
- Output validity:
  - outputs are valid from done until the next accepted start;
  - their values during busy are unspecified and must not be checked.
- y=one or y=0 gives t=0, hence delta=0: outputs equal the latched w and b, and ne=0.

Test Plan:
- Nominal case, sx=2:
  - Stimulus: y=0x00800000, err=0x01000000, lr=0x00800000, b=0, x={0x01000000, 0xFE000000}, w={0x00800000, 0x00400000}.
  - Response: done at edge 7; b_new=0xFFE00000; nw_new={0x00600000, 0x00800000}; ne={0x00200000, 0x00100000}; done high exactly one cycle.
- Truncation floor:
  - Stimulus: y=0x00800000, err=0xFF000000, lr=0x00000001, b=0.
  - Response: delta=0xFFC00000, g=0xFFFFFFFF, b_new=0x00000001.
- Zero gradient:
  - Stimulus: err=0, arbitrary w and b; repeat with y=0x01000000.
  - Response: nw_new==nw, b_new==b, ne all 0.
- start while busy:
  - Stimulus: pulse start again at edge 3 with different operands.
  - Response: result matches the first operands; single done at edge 7; no second done.
- Asynchronous reset mid-operation:
  - Stimulus: drop rst_n between edges 4 and 5, release, then issue a new start.
  - Response: busy, done and all outputs go to 0 immediately, without waiting for a clock edge; the new operation completes normally with correct values.
- Input change after start:
  - Stimulus: alter nx, nw, err and lr one cycle after start.
  - Response: results reflect the latched values only.
